// File: rtl/tx_lmfc_gen_if.sv
// Configuration, SYSREF and strobe/counter bundle between the JESD204B TX link
// layer control and the LMFC generator.
interface tx_lmfc_gen_if;
  logic [7:0] i_F;
  logic [4:0] i_K;
  logic       i_sysref;
  logic       i_sysref_mode;
  logic       i_sysref_rearm;
  logic       o_frame_clk;
  logic       o_lmfc_clk;
  logic [7:0] o_octet_cnt;
  logic [4:0] o_frame_cnt;
  logic       o_lmfc_aligned;
  logic       o_sysref_misalign;

  modport master (
    output i_F, i_K, i_sysref, i_sysref_mode, i_sysref_rearm,
    input  o_frame_clk, o_lmfc_clk, o_octet_cnt, o_frame_cnt,
           o_lmfc_aligned, o_sysref_misalign
  );

  modport slave (
    input  i_F, i_K, i_sysref, i_sysref_mode, i_sysref_rearm,
    output o_frame_clk, o_lmfc_clk, o_octet_cnt, o_frame_cnt,
           o_lmfc_aligned, o_sysref_misalign
  );
endinterface

// File: rtl/tx_lmfc_gen.sv
// Frame/LMFC strobe and octet/frame position generator for the JESD204B TX link
// layer, phase-locked to SYSREF (subclass 1) with misalignment detection.
module tx_lmfc_gen #(
  parameter int unsigned SYSREF_DELAY = 0
) (
  input logic         clk,
  input logic         rst_n,
  tx_lmfc_gen_if.slave bus
);

  localparam logic [3:0] DELAY_INIT = 4'(SYSREF_DELAY);

  logic [7:0] octet_q, octet_d;
  logic [4:0] frame_q, frame_d;
  logic       frame_clk_q, frame_clk_d;
  logic       lmfc_clk_q, lmfc_clk_d;
  logic       aligned_q, aligned_d;
  logic       misalign_q, misalign_d;
  logic       sysref_prev_q, sysref_prev_d;
  logic       armed_q, armed_d;
  logic       pending_q, pending_d;
  logic [3:0] delay_q, delay_d;

  logic       oct_wrap, frm_wrap, nat_lmfc, rise, accept, force_now;
  logic [7:0] nat_octet;
  logic [4:0] nat_frame;

  always_comb begin
    // >= rather than == so a live decrease of F or K wraps on the next edge.
    oct_wrap  = (octet_q >= bus.i_F);
    frm_wrap  = (frame_q >= bus.i_K);
    nat_octet = oct_wrap ? 8'd0 : octet_q + 8'd1;
    nat_frame = oct_wrap ? (frm_wrap ? 5'd0 : frame_q + 5'd1) : frame_q;
    nat_lmfc  = oct_wrap && frm_wrap;

    rise      = bus.i_sysref && !sysref_prev_q;
    // Rearm on the same edge as a rise counts as armed for that rise.
    accept    = rise && !pending_q &&
                (bus.i_sysref_mode || armed_q || bus.i_sysref_rearm);
    force_now = pending_q && (delay_q == 4'd0);

    octet_d       = nat_octet;
    frame_d       = nat_frame;
    frame_clk_d   = oct_wrap;
    lmfc_clk_d    = nat_lmfc;
    aligned_d     = aligned_q;
    misalign_d    = misalign_q;
    sysref_prev_d = bus.i_sysref;
    armed_d       = armed_q;
    pending_d     = pending_q;
    delay_d       = delay_q;

    if (bus.i_sysref_rearm) begin
      armed_d    = 1'b1;
      misalign_d = 1'b0;
    end

    if (pending_q && (delay_q != 4'd0)) begin
      delay_d = delay_q - 4'd1;
    end

    // A force that lands on the natural boundary leaves the phase untouched.
    if (force_now) begin
      octet_d     = 8'd0;
      frame_d     = 5'd0;
      frame_clk_d = 1'b1;
      lmfc_clk_d  = 1'b1;
      pending_d   = 1'b0;
      aligned_d   = 1'b1;
      if (aligned_q && !nat_lmfc) begin
        misalign_d = 1'b1;
      end
    end

    if (accept) begin
      pending_d = 1'b1;
      delay_d   = DELAY_INIT;
      armed_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      octet_q       <= 8'd0;
      frame_q       <= 5'd0;
      frame_clk_q   <= 1'b0;
      lmfc_clk_q    <= 1'b0;
      aligned_q     <= 1'b0;
      misalign_q    <= 1'b0;
      sysref_prev_q <= 1'b0;
      armed_q       <= 1'b1;
      pending_q     <= 1'b0;
      delay_q       <= 4'd0;
    end else begin
      octet_q       <= octet_d;
      frame_q       <= frame_d;
      frame_clk_q   <= frame_clk_d;
      lmfc_clk_q    <= lmfc_clk_d;
      aligned_q     <= aligned_d;
      misalign_q    <= misalign_d;
      sysref_prev_q <= sysref_prev_d;
      armed_q       <= armed_d;
      pending_q     <= pending_d;
      delay_q       <= delay_d;
    end
  end

  assign bus.o_octet_cnt       = octet_q;
  assign bus.o_frame_cnt       = frame_q;
  assign bus.o_frame_clk       = frame_clk_q;
  assign bus.o_lmfc_clk        = lmfc_clk_q;
  assign bus.o_lmfc_aligned    = aligned_q;
  assign bus.o_sysref_misalign = misalign_q;

endmodule
